carrier_nco: RTL
================

Name: carrier_nco

Overview:
- Carrier NCO stage directly downstream of the carrier loop filter.
- Inputs: the loop's lag (frequency offset) and lead (proportional) words, plus the programmed DDC center frequency.
- Forms the total carrier frequency word and integrates it into a 32-bit phase accumulator, advancing on each ddcSync.
- Outputs a 12-bit phase word to the downmix sin/cos stage.
- Includes a holdover supervisor that drops the lead term and flags holdover when the loop stops delivering updates.

Parameters:
- HOLD_COUNT, 1024, ddcSync pulses without carrierFreqEn before entering HOLD.
- PHASE_BITS, 12, width of the phase output (taken from accumulator MSBs).

Ports:
- clk  input  1  system clock
- reset  input  1  synchronous, active-high reset
- ddcSync  input  1  sample-rate enable; accumulator advances on this
- centerFreq  input  32  unsigned NCO center frequency word (2^32 = fs)
- carrierFreqOffset  input  32  signed lag frequency word from the loop
- carrierLeadFreq  input  32  signed lead frequency word from the loop
- carrierFreqEn  input  1  loop output valid strobe
- leadEnable  input  1  1 = include the lead term in the frequency sum
- phaseOffset  input  12  static phase rotation added to the output
- phaseClear  input  1  zero the accumulator (single-cycle pulse)
- phase  output  12  carrier phase to the mixer
- phaseEn  output  1  one-cycle strobe, phase updated
- freqWord  output  32  current total frequency word (status readback)
- holdover  output  1  1 = in HOLD state
- holdCounter  output  16  ddcSync pulses since the last carrierFreqEn, saturating at HOLD_COUNT

Behaviour:
- Interface: one clock, clk. Reset is synchronous and active-high on reset.
- Reset values: all registers 0, including phase, phaseEn, freqWord, holdCounter and the accumulator. State = TRACK, so holdover = 0.
- Capture stage: on carrierFreqEn, register lagReg <= carrierFreqOffset and leadReg <= carrierLeadFreq.
- Sum stage:
  - Registered every clk: freqWord <= centerFreq + lagReg + leadTerm, modulo 2^32 (wrap, no saturation).
  - leadTerm = leadReg when leadEnable = 1 and state = TRACK; otherwise 0.
  - Latency from carrierFreqEn to freqWord is 2 clk.
- Accumulator:
  - On ddcSync: acc <= acc + freqWord, mod 2^32.
  - phaseClear has priority over ddcSync and forces acc <= 0 on the same cycle.
- Output stage:
  - One clk after an accumulator update: phase <= acc[31:32-PHASE_BITS] + phaseOffset, mod 2^12, and phaseEn = 1 for one clk.
  - phaseClear also produces a phaseEn strobe, with phase = phaseOffset.
- Holdover state machine:
  - TRACK: holdCounter increments on each ddcSync without carrierFreqEn. carrierFreqEn clears it to 0, and wins when it coincides with ddcSync. When holdCounter reaches HOLD_COUNT, go to HOLD.
  - HOLD: holdover = 1, leadTerm = 0, lagReg retains its last value (frequency holdover), holdCounter stays at HOLD_COUNT. The first carrierFreqEn returns the state to TRACK, clears the counter and captures the new words on the same cycle.
- Reset mid-operation returns everything to the reset values on the next clk edge regardless of other inputs.
- centerFreq and phaseOffset are quasi-static and sampled every clk, with no capture strobe.

Optional Feature:
- Macro: CARRIER_NCO_DITHER_EN.
- Defined: a 17-bit maximal-length LFSR (x^17 + x^14 + 1, seed 17'h1) steps on each ddcSync. Its low 8 bits are added to acc[19:12] before truncation to phase, spreading truncation spurs. The accumulator itself is not modified. Reset and phaseClear reseed the LFSR.
- Undefined: no LFSR; phase is the pure truncation described above. This is the bit-exact reference mode.

Test Plan:
- Reset, then centerFreq = 32'h10000000, offsets 0, ddcSync every 4 clk → phase steps 0x000, 0x100, 0x200, … wrapping at 0x000 after 16 updates; phaseEn one clk after each ddcSync.
- carrierFreqOffset = 32'h00100000 and carrierLeadFreq = 32'h00010000 strobed with carrierFreqEn, leadEnable = 1 → freqWord = 32'h10110000 exactly 2 clk later; with leadEnable = 0 → 32'h10100000.
- Negative offset 32'hF0000000 with centerFreq = 32'h10000000 → freqWord = 0 and phase constant after the next update (wrap arithmetic check).
- HOLD_COUNT = 8, stop carrierFreqEn → holdover asserts on the 8th ddcSync, lead term dropped from freqWord, lag retained. A single carrierFreqEn coincident with ddcSync → TRACK, holdCounter = 0.
- phaseClear asserted together with ddcSync at acc = 32'h80000000, phaseOffset = 12'h123 → acc = 0, next phase = 12'h123 with phaseEn.
- Reset asserted mid-stream with carrierFreqEn high → all outputs 0 and holdover = 0 after one clk edge; registers stay 0 while reset is held.

Source files
------------

// File: rtl/carrier_nco.sv
// rtl/carrier_nco.sv - carrier NCO: frequency sum, 32-bit phase accumulator, holdover supervisor
// Optional phase dither on truncation is enabled by defining CARRIER_NCO_DITHER_EN.
module carrier_nco #(
   parameter int HOLD_COUNT = 1024,
   parameter int PHASE_BITS = 12
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  ddcSync,
   input  logic [31:0]           centerFreq,
   input  logic [31:0]           carrierFreqOffset,
   input  logic [31:0]           carrierLeadFreq,
   input  logic                  carrierFreqEn,
   input  logic                  leadEnable,
   input  logic [PHASE_BITS-1:0] phaseOffset,
   input  logic                  phaseClear,
   output logic [PHASE_BITS-1:0] phase,
   output logic                  phaseEn,
   output logic [31:0]           freqWord,
   output logic                  holdover,
   output logic [15:0]           holdCounter
);

   typedef enum logic {TRACK, HOLD} state_t;

   localparam logic [15:0] HOLD_LIMIT = 16'(HOLD_COUNT);

   state_t                state, next_state;
   logic [15:0]           next_count;
   logic [31:0]           lag_reg, lead_reg, lead_term;
   logic [31:0]           acc;
   logic                  acc_updated;
   logic [PHASE_BITS-1:0] acc_top;

   always_ff @(posedge clk) begin
      if (reset) begin
         lag_reg  <= '0;
         lead_reg <= '0;
      end else if (carrierFreqEn) begin
         lag_reg  <= carrierFreqOffset;
         lead_reg <= carrierLeadFreq;
      end
   end

   assign lead_term = (leadEnable && state == TRACK) ? lead_reg : '0;

   always_ff @(posedge clk) begin
      if (reset) freqWord <= '0;
      else       freqWord <= centerFreq + lag_reg + lead_term;
   end

   // phaseClear outranks ddcSync; either one schedules an output strobe next clk
   always_ff @(posedge clk) begin
      if (reset) begin
         acc         <= '0;
         acc_updated <= 1'b0;
      end else begin
         acc_updated <= phaseClear | ddcSync;
         if (phaseClear)   acc <= '0;
         else if (ddcSync) acc <= acc + freqWord;
      end
   end

`ifdef CARRIER_NCO_DITHER_EN
   logic [16:0] lfsr;
   logic [19:0] dithered;

   always_ff @(posedge clk) begin
      if (reset || phaseClear) lfsr <= 17'h1;
      else if (ddcSync)        lfsr <= {lfsr[15:0], lfsr[16] ^ lfsr[13]};
   end

   // dither lands on acc[19:12]; the accumulator itself stays exact
   assign dithered = acc[31:12] + {12'd0, lfsr[7:0]};
   assign acc_top  = dithered[19 -: PHASE_BITS];
`else
   assign acc_top  = acc[31 -: PHASE_BITS];
`endif

   always_ff @(posedge clk) begin
      if (reset) begin
         phase   <= '0;
         phaseEn <= 1'b0;
      end else begin
         phaseEn <= acc_updated;
         if (acc_updated) phase <= acc_top + phaseOffset;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state       <= TRACK;
         holdCounter <= '0;
      end else begin
         state       <= next_state;
         holdCounter <= next_count;
      end
   end

   // a loop update always wins over a coincident ddcSync
   always_comb begin
      next_state = state;
      next_count = holdCounter;
      case (state)
         TRACK: begin
            if (carrierFreqEn) begin
               next_count = '0;
            end else if (ddcSync) begin
               next_count = holdCounter + 16'd1;
               if (next_count >= HOLD_LIMIT) next_state = HOLD;
            end
         end
         HOLD: begin
            if (carrierFreqEn) begin
               next_state = TRACK;
               next_count = '0;
            end
         end
      endcase
   end

   assign holdover = (state == HOLD);

endmodule
